// File: rtl/rr_arbiter_4_enc.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_4_enc
// Purpose  : Four-requester round-robin arbiter with registered one-hot grant
//            and matching 2-bit binary grant index. The owner keeps the grant
//            until it drops its request. A one-cycle IDLE gap always separates
//            consecutive grants. The rotating pointer makes the previous
//            owner the lowest-priority client after every release.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_HOLD    : maximum consecutive granted cycles per owner (2..255).
//                 Used only when RR_ARB_TIMEOUT_EN is defined.
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   req         in   4  level request, bit i = client i
//   grant       out  4  registered one-hot grant, 0 when nobody owns
//   grant_id    out  2  binary index of the owner, 0 when not valid
//   grant_valid out  1  high when any grant bit is high
//   timeout     out  1  one-cycle pulse on a forced release
// Configuration macro
//   RR_ARB_TIMEOUT_EN : when defined, ownership is limited to MAX_HOLD
//                       cycles. When undefined, there is no hold limit, the
//                       hold counter is absent, and timeout is tied to 0.
// ============================================================================
module rr_arbiter_4_enc #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic       grant_valid_q, grant_valid_d;

    // Rotating search: the first set request starting at ptr_q, wrapping mod 4.
    logic       win_found;
    logic [1:0] win_id;
    logic [1:0] search_idx;

    always_comb begin
        win_found  = 1'b0;
        win_id     = ptr_q;
        search_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            search_idx = ptr_q + 2'(k);
            if (!win_found && req[search_idx]) begin
                win_found = 1'b1;
                win_id    = search_idx;
            end
        end
    end

    // The registered owner index selects the owner's request bit directly.
    logic owner_req;
    assign owner_req = req[grant_id_q];

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hcnt_q, hcnt_d;
    logic       timeout_q, timeout_d;
`else
    // MAX_HOLD has no effect in this build.
    logic       unused_hold_lim;
    assign unused_hold_lim = ^HOLD_LIM;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
        hcnt_d        = hcnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Outputs are already 0 in IDLE, so only a win changes them.
                if (win_found) begin
                    grant_d       = 4'b0001 << win_id;
                    grant_id_d    = win_id;
                    grant_valid_d = 1'b1;
                    ptr_d         = win_id + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
                    hcnt_d        = 8'd1;
`endif
                    state_d       = S_OWNED;
                end
            end
            S_OWNED: begin
                // An owner drop takes priority over the limit, so a drop at
                // the limit counts as a normal release without timeout.
                if (!owner_req) begin
                    grant_d       = 4'b0000;
                    grant_id_d    = 2'd0;
                    grant_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hcnt_q == HOLD_LIM) begin
                    grant_d       = 4'b0000;
                    grant_id_d    = 2'd0;
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    hcnt_d        = hcnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d       = S_IDLE;
                grant_d       = 4'b0000;
                grant_id_d    = 2'd0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= 2'd0;
            grant_q       <= 4'b0000;
            grant_id_q    <= 2'd0;
            grant_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hcnt_q        <= 8'd0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
            hcnt_q        <= hcnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_4_enc
// Purpose  : Directed testbench for rr_arbiter_4_enc. A table of
//            {req, expected outputs} vectors covers fairness and a single
//            requester. Hand-written sequences cover asynchronous reset, the
//            hold limit (RR_ARB_TIMEOUT_EN defined, MAX_HOLD=4), and unlimited
//            hold (macro undefined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4_enc;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 4;
`else
    localparam int TB_MAX_HOLD = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    rr_arbiter_4_enc #(
        .MAX_HOLD(TB_MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] id, input logic v);
        vec_t e;
        e.r  = r;
        e.g  = g;
        e.id = id;
        e.v  = v;
        tbl.push_back(e);
    endfunction

    task automatic check(input string name, input logic [3:0] eg,
                         input logic [1:0] eid, input logic ev, input logic eto);
        n_cmp++;
        if ({grant, grant_id, grant_valid, timeout} !== {eg, eid, ev, eto}) begin
            n_bad++;
            $display("FAIL %s: got grant=%b id=%0d valid=%b timeout=%b, want grant=%b id=%0d valid=%b timeout=%b",
                     name, grant, grant_id, grant_valid, timeout, eg, eid, ev, eto);
        end
    endtask

    // Drive req at the falling edge, let one rising edge pass, sample at the
    // next falling edge.
    task automatic step(input string name, input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] eid, input logic ev, input logic eto);
        req = r;
        @(posedge clk);
        @(negedge clk);
        check(name, eg, eid, ev, eto);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Fairness from ptr=0: each owner holds 2 cycles, drops 1, reasserts.
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b1110, 4'b0000, 2'd0, 1'b0);
        add(4'b1111, 4'b0010, 2'd1, 1'b1);
        add(4'b1111, 4'b0010, 2'd1, 1'b1);
        add(4'b1101, 4'b0000, 2'd0, 1'b0);
        add(4'b1111, 4'b0100, 2'd2, 1'b1);
        add(4'b1111, 4'b0100, 2'd2, 1'b1);
        add(4'b1011, 4'b0000, 2'd0, 1'b0);
        add(4'b1111, 4'b1000, 2'd3, 1'b1);
        add(4'b1111, 4'b1000, 2'd3, 1'b1);
        add(4'b0111, 4'b0000, 2'd0, 1'b0);
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b1110, 4'b0000, 2'd0, 1'b0);
        add(4'b1111, 4'b0010, 2'd1, 1'b1);
        add(4'b1111, 4'b0010, 2'd1, 1'b1);
        add(4'b1101, 4'b0000, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        // Single requester, client 2 (ptr=2 now).
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
`ifndef RR_ARB_TIMEOUT_EN
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
`endif
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].r, tbl[i].g, tbl[i].id, tbl[i].v, 1'b0);
        end

        // Reset mid-grant (ptr=3: search 3,0,1,2 picks client 2).
        step("rst_pre_grant", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_first", 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("post_rst_rel", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
        // ptr=1: client 1 wins, held for 4 cycles, forced out, then client 3.
        for (int i = 0; i < 4; i++)
            step($sformatf("to_hold%0d", i), 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("to_pulse", 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b1);
        step("to_next", 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
        step("to_rel", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        // ptr=0: client 1 drops in its 4th granted cycle -> normal release.
        for (int i = 0; i < 4; i++)
            step($sformatf("lim_hold%0d", i), 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("lim_drop", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("lim_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
        // No hold limit: client 1 keeps the grant for 20 cycles.
        for (int i = 0; i < 20; i++)
            step($sformatf("nolim%0d", i), 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("nolim_rel", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
